// File: rtl/cc_speed_monitor_pkg.sv
// Shared types and sizing helpers for the multi-channel speed monitor.
package cc_speed_monitor_pkg;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        PEND_HI = 2'd1,
        ALARM   = 2'd2,
        PEND_LO = 2'd3
    } mon_state_e;

    function automatic int unsigned cnt_width(input int unsigned persist);
        return $clog2(persist + 1);
    endfunction

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cc_speed_monitor_channel.sv
// One monitored channel: limit register, persistence FSM with hysteretic
// release, registered active-low alarm and sticky alarm history.
module cc_speed_monitor_channel
    import cc_speed_monitor_pkg::*;
#(
    parameter int unsigned W       = 28,
    parameter int unsigned PERSIST = 3,
    parameter int unsigned HYST    = 0,
    parameter logic [W-1:0] LIMIT_RESET = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data,
    input  logic         valid,
    input  logic         lim_we,
    input  logic [W-1:0] lim_wdata,
    input  logic         sticky_clr,
    output logic         alarm_n,
    output logic         sticky
);

    localparam int unsigned CNT_W = cnt_width(PERSIST);
    localparam logic [CNT_W:0] PERSIST_X = (CNT_W+1)'(PERSIST);
    localparam logic [W:0]     HYST_X    = (W+1)'(HYST);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     limit_q, limit_d;
    logic             sticky_q, sticky_d;
    logic             alarm_n_q, alarm_n_d;

    logic [W:0]       rel_wide;
    logic [W-1:0]     rel;
    logic             over;
    logic             under;
    logic [CNT_W:0]   cnt_inc;
    logic             cnt_done;
    logic             enter_alarm;

    // Release threshold saturates at zero when the limit is below the margin.
    always_comb begin
        rel_wide = {1'b0, limit_q} - HYST_X;
        rel      = ({1'b0, limit_q} < HYST_X) ? '0 : rel_wide[W-1:0];
        over     = (data >= limit_q);
        under    = (data < rel);
        cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
        cnt_done = (cnt_inc == PERSIST_X);
    end

    // In NORMAL/ALARM the counter is zero, so cnt_done also covers PERSIST=1.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        enter_alarm = 1'b0;
        if (valid) begin
            case (state_q)
                NORMAL, PEND_HI: begin
                    if (over) begin
                        if (cnt_done) begin
                            state_d     = ALARM;
                            cnt_d       = '0;
                            enter_alarm = 1'b1;
                        end else begin
                            state_d = PEND_HI;
                            cnt_d   = cnt_inc[CNT_W-1:0];
                        end
                    end else begin
                        state_d = NORMAL;
                        cnt_d   = '0;
                    end
                end
                ALARM, PEND_LO: begin
                    if (under) begin
                        if (cnt_done) begin
                            state_d = NORMAL;
                            cnt_d   = '0;
                        end else begin
                            state_d = PEND_LO;
                            cnt_d   = cnt_inc[CNT_W-1:0];
                        end
                    end else begin
                        state_d = ALARM;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = NORMAL;
                    cnt_d   = '0;
                end
            endcase
        end

        limit_d   = lim_we ? lim_wdata : limit_q;
        sticky_d  = enter_alarm ? 1'b1 : (sticky_clr ? 1'b0 : sticky_q);
        alarm_n_d = !((state_d == ALARM) || (state_d == PEND_LO));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= NORMAL;
            cnt_q     <= '0;
            limit_q   <= LIMIT_RESET;
            sticky_q  <= 1'b0;
            alarm_n_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            limit_q   <= limit_d;
            sticky_q  <= sticky_d;
            alarm_n_q <= alarm_n_d;
        end
    end

    assign alarm_n = alarm_n_q;
    assign sticky  = sticky_q;

endmodule

// File: rtl/cc_speed_monitor.sv
// Multi-channel speed monitor: decodes limit writes, fans samples out to
// per-channel monitors and combines their alarms.
module cc_speed_monitor
    import cc_speed_monitor_pkg::*;
#(
    parameter int unsigned SPEEDMONITOR_DATAWIDTH = 28,
    parameter int unsigned SPEEDMONITOR_CHANNELS  = 4,
    parameter int unsigned SPEEDMONITOR_PERSIST   = 3,
    parameter int unsigned SPEEDMONITOR_HYST      = 0,
    parameter logic [SPEEDMONITOR_DATAWIDTH-1:0] SPEEDMONITOR_LIMIT_RESET = '1,
    localparam int unsigned W     = SPEEDMONITOR_DATAWIDTH,
    localparam int unsigned N     = SPEEDMONITOR_CHANNELS,
    localparam int unsigned SEL_W = sel_width(SPEEDMONITOR_CHANNELS)
) (
    input  logic             CC_SPEEDMONITOR_CLOCK_50,
    input  logic             CC_SPEEDMONITOR_RESET_InHigh,
    input  logic [N*W-1:0]   CC_SPEEDMONITOR_data_InBUS,
    input  logic             CC_SPEEDMONITOR_dataValid_In,
    input  logic             CC_SPEEDMONITOR_limitLoad_InLow,
    input  logic [SEL_W-1:0] CC_SPEEDMONITOR_limitSel_In,
    input  logic [W-1:0]     CC_SPEEDMONITOR_limit_InBUS,
    input  logic             CC_SPEEDMONITOR_stickyClear_In,
    output logic [N-1:0]     CC_SPEEDMONITOR_signal_OutLow,
    output logic [N-1:0]     CC_SPEEDMONITOR_sticky_Out,
    output logic             CC_SPEEDMONITOR_any_OutLow
);

    logic [N-1:0] lim_we;

    // Out-of-range selects match no channel and are dropped.
    for (genvar i = 0; i < N; i++) begin : g_ch
        assign lim_we[i] = !CC_SPEEDMONITOR_limitLoad_InLow &&
                           (CC_SPEEDMONITOR_limitSel_In == SEL_W'(i));

        cc_speed_monitor_channel #(
            .W           (W),
            .PERSIST     (SPEEDMONITOR_PERSIST),
            .HYST        (SPEEDMONITOR_HYST),
            .LIMIT_RESET (SPEEDMONITOR_LIMIT_RESET)
        ) u_ch (
            .clk        (CC_SPEEDMONITOR_CLOCK_50),
            .rst        (CC_SPEEDMONITOR_RESET_InHigh),
            .data       (CC_SPEEDMONITOR_data_InBUS[i*W +: W]),
            .valid      (CC_SPEEDMONITOR_dataValid_In),
            .lim_we     (lim_we[i]),
            .lim_wdata  (CC_SPEEDMONITOR_limit_InBUS),
            .sticky_clr (CC_SPEEDMONITOR_stickyClear_In),
            .alarm_n    (CC_SPEEDMONITOR_signal_OutLow[i]),
            .sticky     (CC_SPEEDMONITOR_sticky_Out[i])
        );
    end

    assign CC_SPEEDMONITOR_any_OutLow = &CC_SPEEDMONITOR_signal_OutLow;

endmodule

// File: tb/tb_cc_speed_monitor.sv
// Directed bench for cc_speed_monitor (W=8, N=4, PERSIST=3, HYST=4), plus a
// three-channel instance for the out-of-range limit select.
module tb_cc_speed_monitor;

    logic        clk;
    logic        rst;
    logic        sclr;

    logic [31:0] data;
    logic        valid;
    logic        load_n;
    logic [1:0]  sel;
    logic [7:0]  lim;
    logic [3:0]  sig;
    logic [3:0]  sticky;
    logic        any_n;

    logic [23:0] data2;
    logic        valid2;
    logic        load2_n;
    logic [1:0]  sel2;
    logic [7:0]  lim2;
    logic [2:0]  sig2;
    logic [2:0]  sticky2;
    logic        any2_n;

    int checks = 0;
    int errors = 0;

    cc_speed_monitor #(
        .SPEEDMONITOR_DATAWIDTH (8),
        .SPEEDMONITOR_CHANNELS  (4),
        .SPEEDMONITOR_PERSIST   (3),
        .SPEEDMONITOR_HYST      (4)
    ) dut (
        .CC_SPEEDMONITOR_CLOCK_50        (clk),
        .CC_SPEEDMONITOR_RESET_InHigh    (rst),
        .CC_SPEEDMONITOR_data_InBUS      (data),
        .CC_SPEEDMONITOR_dataValid_In    (valid),
        .CC_SPEEDMONITOR_limitLoad_InLow (load_n),
        .CC_SPEEDMONITOR_limitSel_In     (sel),
        .CC_SPEEDMONITOR_limit_InBUS     (lim),
        .CC_SPEEDMONITOR_stickyClear_In  (sclr),
        .CC_SPEEDMONITOR_signal_OutLow   (sig),
        .CC_SPEEDMONITOR_sticky_Out      (sticky),
        .CC_SPEEDMONITOR_any_OutLow      (any_n)
    );

    cc_speed_monitor #(
        .SPEEDMONITOR_DATAWIDTH (8),
        .SPEEDMONITOR_CHANNELS  (3),
        .SPEEDMONITOR_PERSIST   (3),
        .SPEEDMONITOR_HYST      (4)
    ) dut3 (
        .CC_SPEEDMONITOR_CLOCK_50        (clk),
        .CC_SPEEDMONITOR_RESET_InHigh    (rst),
        .CC_SPEEDMONITOR_data_InBUS      (data2),
        .CC_SPEEDMONITOR_dataValid_In    (valid2),
        .CC_SPEEDMONITOR_limitLoad_InLow (load2_n),
        .CC_SPEEDMONITOR_limitSel_In     (sel2),
        .CC_SPEEDMONITOR_limit_InBUS     (lim2),
        .CC_SPEEDMONITOR_stickyClear_In  (sclr),
        .CC_SPEEDMONITOR_signal_OutLow   (sig2),
        .CC_SPEEDMONITOR_sticky_Out      (sticky2),
        .CC_SPEEDMONITOR_any_OutLow      (any2_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    // Returns 1 time unit after the n-th rising edge so outputs are settled.
    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_data(input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] c3);
        data = {c3, c2, c1, c0};
    endtask

    task automatic write_lim(input logic [1:0] ch, input logic [7:0] value);
        valid  = 1'b0;
        load_n = 1'b0;
        sel    = ch;
        lim    = value;
        cycle(1);
        load_n = 1'b1;
    endtask

    initial begin
        int seq[5];
        int brk[4];
        seq = '{100, 100, 99, 100, 100};
        brk = '{95, 95, 97, 95};

        rst = 1'b1; sclr = 1'b0;
        data = '0; valid = 1'b0; load_n = 1'b1; sel = '0; lim = '0;
        data2 = '0; valid2 = 1'b0; load2_n = 1'b1; sel2 = '0; lim2 = '0;
        cycle(2);
        rst = 1'b0;
        check_eq("rst_sig",    32'(sig),    32'hF);
        check_eq("rst_sticky", 32'(sticky), 32'h0);
        check_eq("rst_any",    32'(any_n),  32'h1);

        // 254 never reaches the reset limit of 255.
        set_data(8'd254, 8'd254, 8'd254, 8'd254);
        valid = 1'b1;
        cycle(5);
        check_eq("below_rst_lim_sig",    32'(sig),    32'hF);
        check_eq("below_rst_lim_sticky", 32'(sticky), 32'h0);
        check_eq("below_rst_lim_any",    32'(any_n),  32'h1);

        // Reset while ch0 is pending must zero its counter.
        set_data(8'd255, 8'd254, 8'd254, 8'd254);
        cycle(1);
        rst = 1'b1;
        cycle(1);
        rst = 1'b0;
        cycle(2);
        check_eq("midrst_cnt_cleared", 32'(sig), 32'hF);
        cycle(1);
        check_eq("midrst_then_alarm", 32'(sig),    32'hE);
        check_eq("midrst_sticky",     32'(sticky), 32'h1);
        rst = 1'b1;
        cycle(1);
        rst = 1'b0;
        check_eq("rst_again_sig",    32'(sig),    32'hF);
        check_eq("rst_again_sticky", 32'(sticky), 32'h0);

        // ch1 alarm latency.
        write_lim(2'd1, 8'd100);
        set_data(8'd0, 8'd100, 8'd0, 8'd0);
        valid = 1'b1;
        cycle(1);
        check_eq("ch1_edge1", 32'(sig), 32'hF);
        cycle(1);
        check_eq("ch1_edge2", 32'(sig), 32'hF);
        cycle(1);
        check_eq("ch1_edge3_sig",    32'(sig),    32'hD);
        check_eq("ch1_edge3_sticky", 32'(sticky), 32'h2);
        check_eq("ch1_edge3_any",    32'(any_n),  32'h0);

        // ch2: a dip below the limit breaks the run.
        write_lim(2'd2, 8'd100);
        valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_data(8'd0, 8'd100, 8'(seq[k]), 8'd0);
            cycle(1);
        end
        check_eq("ch2_broken_run", 32'(sig), 32'hD);
        set_data(8'd0, 8'd100, 8'd0, 8'd0);
        cycle(1);

        // ch2: invalid gaps do not break the run.
        set_data(8'd0, 8'd100, 8'd100, 8'd0);
        cycle(1);
        valid = 1'b0; cycle(1);
        valid = 1'b1; cycle(1);
        check_eq("ch2_gap_two_valid", 32'(sig), 32'hD);
        valid = 1'b0; cycle(2);
        valid = 1'b1; cycle(1);
        check_eq("ch2_gap_alarm",  32'(sig),    32'h9);
        check_eq("ch2_gap_sticky", 32'(sticky), 32'h6);

        // ch1 release: rel = 100 - 4 = 96.
        set_data(8'd0, 8'd97, 8'd100, 8'd0);
        cycle(3);
        check_eq("ch1_hyst_hold", 32'(sig), 32'h9);
        set_data(8'd0, 8'd95, 8'd100, 8'd0);
        cycle(2);
        check_eq("ch1_pend_lo", 32'(sig), 32'h9);
        cycle(1);
        check_eq("ch1_release", 32'(sig), 32'hB);

        // ch2 interrupted release stays in alarm.
        for (int k = 0; k < 4; k++) begin
            set_data(8'd0, 8'd0, 8'(brk[k]), 8'd0);
            cycle(1);
        end
        check_eq("ch2_interrupted", 32'(sig), 32'hB);
        set_data(8'd0, 8'd0, 8'd100, 8'd0);
        cycle(1);

        // Same-edge write uses the old limit for the compare.
        load_n = 1'b0; sel = 2'd3; lim = 8'd50;
        set_data(8'd0, 8'd0, 8'd100, 8'd60);
        valid = 1'b1;
        cycle(1);
        load_n = 1'b1;
        cycle(2);
        check_eq("ch3_old_limit", 32'(sig), 32'hB);
        sclr = 1'b1;
        cycle(1);
        sclr = 1'b0;
        check_eq("ch3_alarm_sig",         32'(sig),    32'h3);
        check_eq("sticky_set_beats_clr",  32'(sticky), 32'h8);
        check_eq("ch3_alarm_any",         32'(any_n),  32'h0);

        // ch0 limit below HYST: release threshold is 0.
        write_lim(2'd0, 8'd2);
        set_data(8'd5, 8'd0, 8'd100, 8'd60);
        valid = 1'b1;
        cycle(3);
        check_eq("ch0_alarm",        32'(sig),    32'h2);
        check_eq("ch0_alarm_sticky", 32'(sticky), 32'h9);
        set_data(8'd0, 8'd0, 8'd100, 8'd60);
        cycle(5);
        check_eq("ch0_no_release", 32'(sig), 32'h2);
        write_lim(2'd0, 8'd10);
        valid = 1'b1;
        cycle(2);
        check_eq("ch0_pend_lo", 32'(sig), 32'h2);
        cycle(1);
        check_eq("ch0_release",     32'(sig),   32'h3);
        check_eq("ch0_release_any", 32'(any_n), 32'h0);
        valid = 1'b0;

        // Three-channel instance: select 3 addresses no channel.
        load2_n = 1'b0; sel2 = 2'd3; lim2 = 8'd0;
        cycle(1);
        load2_n = 1'b1;
        data2 = {8'd254, 8'd254, 8'd254};
        valid2 = 1'b1;
        cycle(3);
        check_eq("sel_oob_ignored", 32'(sig2), 32'h7);
        valid2 = 1'b0;
        load2_n = 1'b0; sel2 = 2'd2; lim2 = 8'd10;
        cycle(1);
        load2_n = 1'b1;
        data2 = {8'd20, 8'd0, 8'd0};
        valid2 = 1'b1;
        cycle(3);
        check_eq("n3_ch2_alarm",  32'(sig2),    32'h3);
        check_eq("n3_ch2_sticky", 32'(sticky2), 32'h4);
        check_eq("n3_any",        32'(any2_n),  32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
